// File: rtl/uart_tx_feeder_pkg.sv
// Shared definitions for the UART loopback feeder path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Holds the byte width, the default FIFO address width and the feeder FSM
// state encoding used by uart_tx_feeder and its interface.
package uart_tx_feeder_pkg;

   localparam int UART_DATA_W   = 8;
   localparam int FEEDER_ADDR_W = 4;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      LAUNCH    = 2'd1,
      WAIT_DONE = 2'd2
   } feeder_state_e;

endpackage

// File: rtl/uart_tx_feeder_if.sv
// Bundle of the receiver-side, transmitter-side and status signals of the feeder.
// Latency: n/a (wiring only).
// Backpressure: n/a; flow control is carried by i_Tx_Active / i_Tx_Done.
//
// Ports (slave = feeder view):
//   i_Rx_DV, i_Rx_Byte          received byte strobe and data
//   i_Tx_Active, i_Tx_Done      transmitter busy level and end-of-frame pulse
//   i_Clr_Ovf                   clears the sticky overflow flag
//   o_Tx_DV, o_Tx_Byte          single-cycle transmit request and its byte
//   o_Count, o_Empty, o_Full    FIFO occupancy status
//   o_Overflow                  sticky "a byte was dropped"
interface uart_tx_feeder_if
   import uart_tx_feeder_pkg::*;
#(
   parameter int DATA_W = UART_DATA_W,
   parameter int ADDR_W = FEEDER_ADDR_W
);

   logic              i_Rx_DV;
   logic [DATA_W-1:0] i_Rx_Byte;
   logic              i_Tx_Active;
   logic              i_Tx_Done;
   logic              i_Clr_Ovf;
   logic              o_Tx_DV;
   logic [DATA_W-1:0] o_Tx_Byte;
   logic [ADDR_W:0]   o_Count;
   logic              o_Empty;
   logic              o_Full;
   logic              o_Overflow;

   // The feeder itself.
   modport slave (
      input  i_Rx_DV, i_Rx_Byte, i_Tx_Active, i_Tx_Done, i_Clr_Ovf,
      output o_Tx_DV, o_Tx_Byte, o_Count, o_Empty, o_Full, o_Overflow
   );

   // The surrounding loopback top (receiver, transmitter, control).
   modport master (
      output i_Rx_DV, i_Rx_Byte, i_Tx_Active, i_Tx_Done, i_Clr_Ovf,
      input  o_Tx_DV, o_Tx_Byte, o_Count, o_Empty, o_Full, o_Overflow
   );

endinterface

// File: rtl/uart_sync_fifo.sv
// Synchronous circular-buffer FIFO with occupancy counter.
// Latency: a pushed entry is visible at o_Head one edge after the push.
// Backpressure: push while full is refused (o_Push_Drop) unless a pop occurs on the same edge.
//
// Ports:
//   i_Clock, i_Rst_n      rising-edge clock, async active-low reset (pointers/count only)
//   i_Push, i_Push_Data   write request and data
//   i_Pop                 read request; caller guarantees the FIFO is not empty
//   o_Head                entry at the read pointer (combinational)
//   o_Count               occupancy 0..2**ADDR_W
//   o_Full, o_Empty       occupancy flags
//   o_Push_Drop           a push was refused on this edge
module uart_sync_fifo #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
) (
   input  logic              i_Clock,
   input  logic              i_Rst_n,
   input  logic              i_Push,
   input  logic [DATA_W-1:0] i_Push_Data,
   input  logic              i_Pop,
   output logic [DATA_W-1:0] o_Head,
   output logic [ADDR_W:0]   o_Count,
   output logic              o_Full,
   output logic              o_Empty,
   output logic              o_Push_Drop
);

   localparam int              DEPTH   = 2 ** ADDR_W;
   localparam logic [ADDR_W:0] CNT_MAX = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W + 1)'(1);
   localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic              push_ok;

   assign o_Full  = (count_q == CNT_MAX);
   assign o_Empty = (count_q == '0);
   assign o_Count = count_q;
   assign o_Head  = mem_q[rd_ptr_q];

   // When full, a same-edge pop frees the slot the write pointer is aimed at;
   // the head is read out before the edge so the overwrite is safe.
   assign push_ok     = i_Push && (!o_Full || i_Pop);
   assign o_Push_Drop = i_Push && !push_ok;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (i_Pop) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      case ({push_ok, i_Pop})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge i_Clock or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is deliberately left out of reset; the pointers define validity.
   always_ff @(posedge i_Clock) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= i_Push_Data;
      end
   end

endmodule

// File: rtl/uart_tx_feeder.sv
// Elastic byte buffer between UART RX and UART TX that launches one TX request per queued byte.
// Latency: byte pushed into an empty FIFO at edge N pops at N+1; o_Tx_DV is high from N+2 to N+3.
// Backpressure: none toward RX; bytes arriving while full (no same-edge pop) are dropped and flagged.
//
// Ports:
//   i_Clock, i_Rst_n   rising-edge clock, async active-low reset (flushes FIFO, aborts FSM)
//   bus (slave)        RX strobe/byte, TX active/done, overflow clear in;
//                      TX request/byte, occupancy, empty/full, sticky overflow out
module uart_tx_feeder
   import uart_tx_feeder_pkg::*;
#(
   parameter int DATA_W = UART_DATA_W,
   parameter int ADDR_W = FEEDER_ADDR_W
) (
   input  logic             i_Clock,
   input  logic             i_Rst_n,
   uart_tx_feeder_if.slave  bus
);

   feeder_state_e     state_q;
   logic              tx_dv_q;
   logic [DATA_W-1:0] tx_byte_q;
   logic              ovf_q, ovf_d;

   logic [DATA_W-1:0] fifo_head;
   logic [ADDR_W:0]   fifo_count;
   logic              fifo_full;
   logic              fifo_empty;
   logic              fifo_drop;
   logic              pop_w;

   // The head is taken only once the previous frame has finished and the
   // transmitter reports idle, so the FIFO is never popped while empty.
   assign pop_w = (state_q == IDLE) && !fifo_empty && !bus.i_Tx_Active;

   uart_sync_fifo #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_fifo (
      .i_Clock     (i_Clock),
      .i_Rst_n     (i_Rst_n),
      .i_Push      (bus.i_Rx_DV),
      .i_Push_Data (bus.i_Rx_Byte),
      .i_Pop       (pop_w),
      .o_Head      (fifo_head),
      .o_Count     (fifo_count),
      .o_Full      (fifo_full),
      .o_Empty     (fifo_empty),
      .o_Push_Drop (fifo_drop)
   );

   // Launch FSM. The request register is loaded on the edge that leaves
   // LAUNCH, so the one-cycle o_Tx_DV pulse sits in the first WAIT_DONE
   // cycle; i_Tx_Done is only honoured from the edge after that.
   always_ff @(posedge i_Clock or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         state_q   <= IDLE;
         tx_dv_q   <= 1'b0;
         tx_byte_q <= '0;
      end else begin
         tx_dv_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (pop_w) begin
                  tx_byte_q <= fifo_head;
                  state_q   <= LAUNCH;
               end
            end
            LAUNCH: begin
               tx_dv_q <= 1'b1;
               state_q <= WAIT_DONE;
            end
            WAIT_DONE: begin
               if (bus.i_Tx_Done) begin
                  state_q <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   // A drop on the same edge as a clear wins, so no overflow event is lost.
   always_comb begin
      ovf_d = ovf_q;
      if (fifo_drop) begin
         ovf_d = 1'b1;
      end else if (bus.i_Clr_Ovf) begin
         ovf_d = 1'b0;
      end
   end

   always_ff @(posedge i_Clock or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         ovf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
      end
   end

   assign bus.o_Tx_DV    = tx_dv_q;
   assign bus.o_Tx_Byte  = tx_byte_q;
   assign bus.o_Count    = fifo_count;
   assign bus.o_Empty    = fifo_empty;
   assign bus.o_Full     = fifo_full;
   assign bus.o_Overflow = ovf_q;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Self-checking bench for uart_tx_feeder: queue-based reference model plus scoreboard.
module tb_uart_tx_feeder;

   localparam int DW    = 8;
   localparam int AW    = 4;
   localparam int DEPTH = 16;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   uart_tx_feeder_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

   uart_tx_feeder #(.DATA_W(DW), .ADDR_W(AW)) dut (
      .i_Clock (clk),
      .i_Rst_n (rst_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   // Stimulus controls
   logic          rx_dv      = 1'b0;
   logic [DW-1:0] rx_byte    = '0;
   logic          clr        = 1'b0;
   logic          force_busy = 1'b0;
   logic          tx_hold    = 1'b0;
   logic          stray_done = 1'b0;
   int            tx_len     = 100;

   // Transmitter model state
   logic tx_busy    = 1'b0;
   logic done_pulse = 1'b0;
   int   tx_cnt     = 0;

   assign bus.i_Rx_DV     = rx_dv;
   assign bus.i_Rx_Byte   = rx_byte;
   assign bus.i_Clr_Ovf   = clr;
   assign bus.i_Tx_Active = force_busy | tx_busy;
   assign bus.i_Tx_Done   = done_pulse | stray_done;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic [DW-1:0] b;
      int            due;
   } exp_t;

   logic [DW-1:0] m_q[$];
   exp_t          sb[$];
   logic          m_ready   = 1'b1;
   logic          m_ovf     = 1'b0;
   logic [DW-1:0] m_tx_byte = '0;
   int            m_pop_edge = 0;
   int            cyc = 0;

   // Each edge: a byte leaves when the previous frame is finished and the
   // transmitter is idle; its request is due one edge after it leaves. A byte
   // arriving with 16 already queued is lost unless one leaves on that edge.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_q.delete();
         sb.delete();
         m_ready   = 1'b1;
         m_ovf     = 1'b0;
         m_tx_byte = '0;
      end else begin
         int  sz;
         logic pop, acc;
         cyc++;
         sz  = m_q.size();
         pop = m_ready && (sz > 0) && !bus.i_Tx_Active;
         acc = rx_dv && ((sz < DEPTH) || pop);
         if (pop) begin
            m_tx_byte  = m_q.pop_front();
            sb.push_back('{m_tx_byte, cyc + 1});
            m_ready    = 1'b0;
            m_pop_edge = cyc;
         end else if (!m_ready && bus.i_Tx_Done && (cyc >= m_pop_edge + 2)) begin
            m_ready = 1'b1;
         end
         if (acc) m_q.push_back(rx_byte);
         if (rx_dv && !acc) m_ovf = 1'b1;
         else if (clr)      m_ovf = 1'b0;
      end
   end

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      chk("count",    32'(bus.o_Count),    32'(m_q.size()));
      chk("empty",    32'(bus.o_Empty),    32'(m_q.size() == 0));
      chk("full",     32'(bus.o_Full),     32'(m_q.size() == DEPTH));
      chk("overflow", 32'(bus.o_Overflow), 32'(m_ovf));
      chk("tx_byte",  32'(bus.o_Tx_Byte),  32'(m_tx_byte));
      if (sb.size() > 0 && sb[0].due < cyc) begin
         checks++;
         errors++;
         $display("FAIL dv_missing: no request for byte %0h due at edge %0d", sb[0].b, sb[0].due);
         void'(sb.pop_front());
      end
      if (bus.o_Tx_DV) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL dv_spurious: request with byte %0h, none expected", bus.o_Tx_Byte);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("dv_edge", 32'(cyc), 32'(e.due));
            chk("dv_byte", 32'(bus.o_Tx_Byte), 32'(e.b));
         end
      end
   end

   // ---------------- transmitter model ----------------
   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         #1;
         done_pulse = 1'b0;
         if (!rst_n) begin
            tx_busy = 1'b0;
            tx_cnt  = 0;
         end else if (!tx_busy) begin
            if (bus.o_Tx_DV) begin
               tx_busy = 1'b1;
               tx_cnt  = tx_len;
            end
         end else if (!tx_hold) begin
            if (tx_cnt > 1) tx_cnt--;
            else begin
               tx_busy    = 1'b0;
               done_pulse = 1'b1;
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [DW-1:0] b);
      rx_dv   = 1'b1;
      rx_byte = b;
      step();
      rx_dv   = 1'b0;
   endtask

   task automatic wait_drain(input int max, input string tag);
      int n;
      n = 0;
      while ((m_q.size() != 0 || sb.size() != 0 || tx_busy || !m_ready) && n < max) begin
         step();
         n++;
      end
      checks++;
      if (n >= max) begin
         errors++;
         $display("FAIL drain_%s: still busy after %0d cycles, queued %0d", tag, n, m_q.size());
      end
   endtask

   initial begin
      // Reset
      rst_n = 1'b0;
      repeat (3) step();
      chk("rst_count", 32'(bus.o_Count), 0);
      chk("rst_empty", 32'(bus.o_Empty), 1);
      chk("rst_dv",    32'(bus.o_Tx_DV), 0);
      rst_n = 1'b1;
      step();

      // 1: single byte, latency
      tx_len = 20;
      push(8'hA5);
      chk("t1_count_after_push", 32'(bus.o_Count), 1);
      step();
      chk("t1_count_after_pop", 32'(bus.o_Count), 0);
      chk("t1_dv_not_yet", 32'(bus.o_Tx_DV), 0);
      step();
      chk("t1_dv", 32'(bus.o_Tx_DV), 1);
      chk("t1_byte", 32'(bus.o_Tx_Byte), 32'h A5);
      wait_drain(200, "t1");

      // Stray done while idle must be ignored
      stray_done = 1'b1;
      step();
      stray_done = 1'b0;
      repeat (3) step();

      // 2: burst while busy, then slow drain
      force_busy = 1'b1;
      for (int i = 1; i <= 5; i++) push(DW'(i));
      step();
      chk("t2_count", 32'(bus.o_Count), 5);
      chk("t2_no_dv", 32'(bus.o_Tx_DV), 0);
      tx_len = 100;
      force_busy = 1'b0;
      wait_drain(1500, "t2");

      // 3: overflow
      force_busy = 1'b1;
      for (int i = 0; i < 17; i++) begin
         push(DW'(8'h10 + i));
         if (i == 15) chk("t3_full", 32'(bus.o_Full), 1);
      end
      chk("t3_ovf", 32'(bus.o_Overflow), 1);
      chk("t3_count", 32'(bus.o_Count), 16);
      clr = 1'b1;
      step();
      clr = 1'b0;
      chk("t3_ovf_clr", 32'(bus.o_Overflow), 0);
      // drop and clear on the same edge: drop wins
      clr = 1'b1;
      push(8'h21);
      clr = 1'b0;
      chk("t3_ovf_set_wins", 32'(bus.o_Overflow), 1);
      clr = 1'b1;
      step();
      clr = 1'b0;
      chk("t3_ovf_clr2", 32'(bus.o_Overflow), 0);

      // 4: full, simultaneous pop and push
      tx_len = 6;
      force_busy = 1'b0;
      push(8'h77);
      chk("t4_count", 32'(bus.o_Count), 16);
      chk("t4_ovf", 32'(bus.o_Overflow), 0);
      wait_drain(800, "t4");

      // 5: wrap-around stream
      tx_len = 4;
      for (int i = 0; i < 40; i++) begin
         push(DW'($urandom_range(0, 255)));
         repeat ($urandom_range(0, 4)) step();
      end
      wait_drain(2000, "t5");

      // 6: reset while waiting for done with 3 queued
      tx_len  = 5;
      tx_hold = 1'b1;
      for (int i = 0; i < 4; i++) push(DW'(8'hC0 + i));
      repeat (5) step();
      chk("t6_count_before", 32'(bus.o_Count), 3);
      rst_n = 1'b0;
      #1;
      chk("t6_dv",    32'(bus.o_Tx_DV), 0);
      chk("t6_count", 32'(bus.o_Count), 0);
      chk("t6_empty", 32'(bus.o_Empty), 1);
      step();
      step();
      rst_n   = 1'b1;
      tx_hold = 1'b0;
      repeat (20) step();
      push(8'h3C);
      wait_drain(200, "t6");
      repeat (3) step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
